// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a single-outstanding request port with
// programmable wait states, byte-lane steering and load extension. Optional: MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    output logic        resp_valid,
    output logic [31:0] mem_data_out,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in S_IDLE, and the requester holds its request until taken.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_next;
    logic         r_read;
    logic         r_write;
    logic [2:0]   r_type;
    logic [AW+1:0] r_addr;
    logic [31:0]  r_wdata;
    logic [31:0]  r_mem [DEPTH_WORDS];

    logic         w_accept;
    logic [AW-1:0] w_idx;
    logic         w_is_b;
    logic         w_is_h;
    logic         w_is_w;
    logic         w_type_bad;
    logic         w_misalign;
    logic         w_err;
    logic [31:0]  w_word;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [31:0]  w_load;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic         w_we;
    logic         w_unused_addr;

    assign w_accept      = req_valid && (r_state == S_IDLE);
    assign w_unused_addr = ^mem_addr[31:AW+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_type  <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_read  <= mem_read;
                r_write <= mem_write;
                r_type  <= mem_type;
                r_addr  <= mem_addr[AW+1:0];
                r_wdata <= mem_wr_data;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next     = S_RESP;
                        w_cnt_next = 4'd0;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next     = S_RESP;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign dbg_state  = r_state;

    assign w_idx      = r_addr[AW+1:2];
    assign w_is_b     = (r_type[1:0] == 2'b00);
    assign w_is_h     = (r_type[1:0] == 2'b01);
    assign w_is_w     = (r_type == 3'b010);
    assign w_type_bad = (r_type == 3'b011) || (r_type[2:1] == 2'b11);

`ifdef MISALIGN_CHECK_EN
    assign w_misalign = (w_is_h && r_addr[0]) || (w_is_w && (r_addr[1:0] != 2'b00));
`else
    // Halfword/word accesses silently force alignment by ignoring low address bits.
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_type_bad || (r_read && r_write) || (!r_read && !r_write)
                   || (r_write && r_type[2]) || w_misalign;

    assign w_word = r_mem[w_idx];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    // r_type[2] marks the unsigned load variants.
    always_comb begin
        w_load = w_word;
        if (w_is_b) begin
            w_load = {{24{~r_type[2] & w_byte[7]}}, w_byte};
        end else if (w_is_h) begin
            w_load = {{16{~r_type[2] & w_half[15]}}, w_half};
        end
    end

    assign mem_data_out = (resp_valid && r_read && !w_err) ? w_load : 32'd0;
    assign resp_err     = resp_valid && w_err;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        if (w_is_b) begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wdata[7:0]}};
        end else if (w_is_h) begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wdata[15:0]}};
        end
    end

    assign w_we = resp_valid && r_write && !w_err;

    // RAM contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance share one request stream; results compared against hand-computed values.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_type = 3'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wr_data = 32'd0;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] mem_data_out;
    logic [1:0]  dbg_state;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] mem_data_out0;
    logic [1:0]  dbg_state0;

    int checks = 0;
    int errors = 0;

    logic [31:0] r_d, r_d0;
    logic        r_e, r_e0;
    int          r_lat, r_lat0;

    localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010,
                           T_BU = 3'b100, T_HU = 3'b101;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .resp_valid(resp_valid),
        .mem_data_out(mem_data_out), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .resp_valid(resp_valid0),
        .mem_data_out(mem_data_out0), .resp_err(resp_err0), .dbg_state(dbg_state0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One request, held until accepted, then wait (bounded) for both responses.
    task automatic xact(input logic rd, input logic wr, input logic [2:0] ty,
                        input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        mem_type = ty; mem_addr = ad; mem_wr_data = wd;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = 32'hFFFF_FFFF; mem_wr_data = 32'h5A5A_5A5A;
        r_d = 32'hXXXX_XXXX; r_e = 1'bx; r_lat = 0;
        r_d0 = 32'hXXXX_XXXX; r_e0 = 1'bx; r_lat0 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_valid0 && r_lat0 == 0) begin
                r_lat0 = i; r_d0 = mem_data_out0; r_e0 = resp_err0;
            end
            if (resp_valid) begin
                r_lat = i; r_d = mem_data_out; r_e = resp_err;
                break;
            end
        end
    endtask

    initial begin
        // reset and idle
        repeat (2) @(negedge clk);
        chk("in_reset_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {req_ready, resp_valid, resp_err, mem_data_out[28:0]}, 32'h8000_0000);
        end

        // SW then LW, latency accept+3
        xact(1'b0, 1'b1, T_W, 32'h10, 32'h8000_00F0);
        chk("sw10_lat", r_lat, 3);
        chk("sw10_err", {31'd0, r_e}, 32'd0);
        chk("sw10_data", r_d, 32'd0);
        chk("sw10_lat0", r_lat0, 1);
        xact(1'b1, 1'b0, T_W, 32'h10, 32'h0);
        chk("lw10_lat", r_lat, 3);
        chk("lw10_data", r_d, 32'h8000_00F0);
        chk("lw10_err", {31'd0, r_e}, 32'd0);
        chk("lw10_lat0", r_lat0, 1);
        chk("lw10_data0", r_d0, 32'h8000_00F0);

        // byte store and signed/unsigned byte loads
        xact(1'b0, 1'b1, T_B, 32'h13, 32'h1234_56AB);
        chk("sb13_err", {31'd0, r_e}, 32'd0);
        xact(1'b1, 1'b0, T_B, 32'h13, 32'h0);
        chk("lb13_data", r_d, 32'hFFFF_FFAB);
        xact(1'b1, 1'b0, T_BU, 32'h13, 32'h0);
        chk("lbu13_data", r_d, 32'h0000_00AB);
        xact(1'b1, 1'b0, T_W, 32'h10, 32'h0);
        chk("lw10_after_sb", r_d, 32'hAB00_00F0);

        // odd halfword
        xact(1'b1, 1'b0, T_H, 32'h11, 32'h0);
`ifdef MISALIGN_CHECK_EN
        chk("lh11_err", {31'd0, r_e}, 32'd1);
        chk("lh11_data", r_d, 32'd0);
`else
        chk("lh11_err", {31'd0, r_e}, 32'd0);
        chk("lh11_data", r_d, 32'h0000_00F0);
`endif

        // upper halfword signed/unsigned
        xact(1'b1, 1'b0, T_H, 32'h12, 32'h0);
        chk("lh12_data", r_d, 32'hFFFF_AB00);
        xact(1'b1, 1'b0, T_HU, 32'h12, 32'h0);
        chk("lhu12_data", r_d, 32'h0000_AB00);

        // error cases leave RAM untouched
        xact(1'b1, 1'b1, T_W, 32'h10, 32'hDEAD_BEEF);
        chk("rdwr_err", {31'd0, r_e}, 32'd1);
        chk("rdwr_data", r_d, 32'd0);
        chk("rdwr_lat", r_lat, 3);
        xact(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        chk("type011_err", {31'd0, r_e}, 32'd1);
        chk("type011_data", r_d, 32'd0);
        xact(1'b0, 1'b1, T_BU, 32'h10, 32'h0000_0011);
        chk("sbu_err", {31'd0, r_e}, 32'd1);
        xact(1'b0, 1'b1, 3'b111, 32'h10, 32'h0000_0022);
        chk("type111_err", {31'd0, r_e}, 32'd1);
        xact(1'b0, 1'b0, T_W, 32'h10, 32'h0);
        chk("none_err", {31'd0, r_e}, 32'd1);
        xact(1'b1, 1'b0, T_W, 32'h10, 32'h0);
        chk("lw10_after_errs", r_d, 32'hAB00_00F0);
        chk("lw10_after_errs_e", {31'd0, r_e}, 32'd0);

        // halfword store into upper lanes, then word read at misaligned address
        xact(1'b0, 1'b1, T_H, 32'h12, 32'hFFFF_5678);
        xact(1'b1, 1'b0, T_W, 32'h10, 32'h0);
        chk("lw10_after_sh", r_d, 32'h5678_00F0);
        xact(1'b1, 1'b0, T_W, 32'h12, 32'h0);
`ifdef MISALIGN_CHECK_EN
        chk("lw12_err", {31'd0, r_e}, 32'd1);
        chk("lw12_data", r_d, 32'd0);
`else
        chk("lw12_err", {31'd0, r_e}, 32'd0);
        chk("lw12_data", r_d, 32'h5678_00F0);
`endif

        // address aliasing
        xact(1'b0, 1'b1, T_W, 32'h1000, 32'hCAFE_F00D);
        xact(1'b1, 1'b0, T_W, 32'h0, 32'h0);
        chk("alias_data", r_d, 32'hCAFE_F00D);
        chk("alias_data0", r_d0, 32'hCAFE_F00D);

        // reset during WAIT abandons the store
        xact(1'b0, 1'b1, T_W, 32'h20, 32'h1111_2222);
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        mem_type = T_W; mem_addr = 32'h20; mem_wr_data = 32'h0000_1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("wait_ready_low", {30'd0, dbg_state == 2'd1, req_ready}, 32'd2);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        rst = 1'b0;
        xact(1'b1, 1'b0, T_W, 32'h20, 32'h0);
        chk("lw20_after_rst", r_d, 32'h1111_2222);
        chk("lw20_lat", r_lat, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
